// File: rtl/pc_sequencer.sv
// PC sequencer: boot, fetch, execute, update, fault and halt control for the PC register.
// Every output is a flop loaded with the value that belongs to the state being entered.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter logic [31:0] EXC_VECTOR   = 32'h00000180,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic        Clock_in,
    input  logic        Signal_reset,
    input  logic [31:0] Pc_in,
    input  logic        Mem_ready,
    input  logic        Exec_done,
    input  logic        Jump_req,
    input  logic [31:0] Jump_target,
    input  logic        Branch_req,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    input  logic        Stall,
    input  logic        Halt_req,
    output logic [31:0] Pc_next,
    output logic        Pc_write,
    output logic        Fetch_req,
    output logic [2:0]  State,
    output logic        Fault
);

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        UPDATE = 3'd3,
        FAULT  = 3'd4,
        HALT   = 3'd5
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e      state_q;
    logic [31:0] pc_next_q;
    logic        pc_write_q;
    logic        fetch_q;
    logic        fault_q;
    logic [7:0]  wait_q;

    logic [31:0] target_d;
    logic        misaligned_d;

    always_comb begin
        target_d = Pc_in + 32'd4;
        if (Jump_req) begin
            target_d = Jump_target;
        end else if (Branch_req && Branch_taken) begin
            target_d = Branch_target;
        end
        misaligned_d = (target_d[1:0] != 2'b00);
    end

    // BOOT spends one cycle idle after reset, then one cycle presenting the write.
    always_ff @(posedge Clock_in) begin
        if (Signal_reset) begin
            state_q    <= BOOT;
            pc_next_q  <= '0;
            pc_write_q <= 1'b0;
            fetch_q    <= 1'b0;
            fault_q    <= 1'b0;
            wait_q     <= '0;
        end else if (Stall && state_q != BOOT) begin
            pc_write_q <= 1'b0;
            fetch_q    <= 1'b0;
        end else begin
            pc_write_q <= 1'b0;
            fetch_q    <= 1'b0;
            case (state_q)
                BOOT: begin
                    if (!pc_write_q) begin
                        pc_write_q <= 1'b1;
                        pc_next_q  <= RESET_VECTOR;
                    end else begin
                        state_q <= FETCH;
                        fetch_q <= 1'b1;
                        wait_q  <= '0;
                    end
                end
                FETCH: begin
                    if (Mem_ready) begin
                        state_q <= EXEC;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q    <= FAULT;
                        pc_next_q  <= EXC_VECTOR;
                        pc_write_q <= 1'b1;
                        fault_q    <= 1'b1;
                        wait_q     <= '0;
                    end else begin
                        wait_q  <= wait_q + 8'd1;
                        fetch_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (Exec_done) begin
                        pc_write_q <= 1'b1;
                        if (misaligned_d) begin
                            state_q   <= FAULT;
                            pc_next_q <= EXC_VECTOR;
                            fault_q   <= 1'b1;
                        end else begin
                            state_q   <= UPDATE;
                            pc_next_q <= target_d;
                        end
                    end
                end
                UPDATE: begin
                    if (Halt_req) begin
                        state_q <= HALT;
                    end else begin
                        state_q <= FETCH;
                        fetch_q <= 1'b1;
                        wait_q  <= '0;
                    end
                end
                FAULT: begin
                    state_q <= FETCH;
                    fetch_q <= 1'b1;
                    wait_q  <= '0;
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

    assign Pc_next   = pc_next_q;
    assign Pc_write  = pc_write_q;
    assign Fetch_req = fetch_q;
    assign State     = state_q;
    assign Fault     = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, sequencing, priority, faults,
// fetch timeout with stall, wrap, halt and reset priority.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        mem_ready;
    logic        exec_done;
    logic        jump_req;
    logic [31:0] jump_target;
    logic        branch_req;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic        halt_req;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        fetch_req;
    logic [2:0]  state;
    logic        fault;

    int checks;
    int fails;

    pc_sequencer dut (
        .Clock_in      (clk),
        .Signal_reset  (rst),
        .Pc_in         (pc_in),
        .Mem_ready     (mem_ready),
        .Exec_done     (exec_done),
        .Jump_req      (jump_req),
        .Jump_target   (jump_target),
        .Branch_req    (branch_req),
        .Branch_taken  (branch_taken),
        .Branch_target (branch_target),
        .Stall         (stall),
        .Halt_req      (halt_req),
        .Pc_next       (pc_next),
        .Pc_write      (pc_write),
        .Fetch_req     (fetch_req),
        .State         (state),
        .Fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pc_in = '0; mem_ready = 0; exec_done = 0;
        jump_req = 0; jump_target = '0;
        branch_req = 0; branch_taken = 0; branch_target = '0;
        stall = 0; halt_req = 0;
        step();
        step();
        checks++;
        if (state !== 3'd0 || pc_write !== 1'b0 || fetch_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl state=%0d pw=%b fr=%b exp 0/0/0",
                     state, pc_write, fetch_req);
        end
        checks++;
        if (pc_next !== 32'h0 || fault !== 1'b0) begin
            fails++;
            $display("FAIL reset_data pc_next=%h fault=%b exp 0/0", pc_next, fault);
        end
    endtask

    task automatic test_boot();
        rst = 1'b0;
        step();
        checks++;
        if (state !== 3'd0 || pc_write !== 1'b1 || pc_next !== 32'h0) begin
            fails++;
            $display("FAIL boot_write state=%0d pw=%b pc_next=%h exp 0/1/0",
                     state, pc_write, pc_next);
        end
        step();
        checks++;
        if (state !== 3'd1 || pc_write !== 1'b0 || fetch_req !== 1'b1) begin
            fails++;
            $display("FAIL boot_fetch state=%0d pw=%b fr=%b exp 1/0/1",
                     state, pc_write, fetch_req);
        end
    endtask

    task automatic test_sequential();
        mem_ready = 1'b1;
        step();
        checks++;
        if (state !== 3'd2 || fetch_req !== 1'b0) begin
            fails++;
            $display("FAIL seq_exec state=%0d fr=%b exp 2/0", state, fetch_req);
        end
        mem_ready = 1'b0;
        pc_in = 32'h00000010;
        exec_done = 1'b1;
        step();
        checks++;
        if (state !== 3'd3 || pc_write !== 1'b1 || pc_next !== 32'h00000014) begin
            fails++;
            $display("FAIL seq_update state=%0d pw=%b pc_next=%h exp 3/1/00000014",
                     state, pc_write, pc_next);
        end
        exec_done = 1'b0;
        step();
        checks++;
        if (state !== 3'd1 || pc_write !== 1'b0 || fetch_req !== 1'b1) begin
            fails++;
            $display("FAIL seq_refetch state=%0d pw=%b fr=%b exp 1/0/1",
                     state, pc_write, fetch_req);
        end
    endtask

    task automatic test_jump_priority();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        jump_req = 1'b1; jump_target = 32'h00000100;
        branch_req = 1'b1; branch_taken = 1'b1; branch_target = 32'h00000200;
        exec_done = 1'b1;
        stall = 1'b1;
        step();
        checks++;
        if (state !== 3'd2 || pc_write !== 1'b0) begin
            fails++;
            $display("FAIL jump_stall state=%0d pw=%b exp 2/0", state, pc_write);
        end
        stall = 1'b0;
        step();
        checks++;
        if (state !== 3'd3 || pc_write !== 1'b1 || pc_next !== 32'h00000100) begin
            fails++;
            $display("FAIL jump_prio state=%0d pw=%b pc_next=%h exp 3/1/00000100",
                     state, pc_write, pc_next);
        end
        exec_done = 1'b0; jump_req = 1'b0;
        branch_req = 1'b0; branch_taken = 1'b0;
        step();
    endtask

    task automatic test_misaligned_branch();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        branch_req = 1'b1; branch_taken = 1'b1; branch_target = 32'h00000102;
        exec_done = 1'b1;
        step();
        checks++;
        if (state !== 3'd4 || pc_write !== 1'b1 || pc_next !== 32'h00000180 || fault !== 1'b1) begin
            fails++;
            $display("FAIL mis_fault state=%0d pw=%b pc_next=%h fault=%b exp 4/1/00000180/1",
                     state, pc_write, pc_next, fault);
        end
        branch_req = 1'b0; branch_taken = 1'b0; exec_done = 1'b0;
        step();
        checks++;
        if (state !== 3'd1 || pc_write !== 1'b0 || fetch_req !== 1'b1 || fault !== 1'b1) begin
            fails++;
            $display("FAIL mis_recover state=%0d pw=%b fr=%b fault=%b exp 1/0/1/1",
                     state, pc_write, fetch_req, fault);
        end
    endtask

    task automatic test_timeout();
        repeat (14) step();
        checks++;
        if (state !== 3'd1 || fetch_req !== 1'b1) begin
            fails++;
            $display("FAIL tmo_wait state=%0d fr=%b exp 1/1", state, fetch_req);
        end
        step();
        checks++;
        if (state !== 3'd4 || pc_write !== 1'b1 || pc_next !== 32'h00000180) begin
            fails++;
            $display("FAIL tmo_fault state=%0d pw=%b pc_next=%h exp 4/1/00000180",
                     state, pc_write, pc_next);
        end
        step();
    endtask

    task automatic test_timeout_stall();
        repeat (5) step();
        stall = 1'b1;
        repeat (5) step();
        checks++;
        if (state !== 3'd1 || fetch_req !== 1'b0 || pc_write !== 1'b0) begin
            fails++;
            $display("FAIL stl_hold state=%0d fr=%b pw=%b exp 1/0/0",
                     state, fetch_req, pc_write);
        end
        stall = 1'b0;
        repeat (9) step();
        checks++;
        if (state !== 3'd1) begin
            fails++;
            $display("FAIL stl_wait state=%0d exp 1", state);
        end
        step();
        checks++;
        if (state !== 3'd4) begin
            fails++;
            $display("FAIL stl_fault state=%0d exp 4", state);
        end
        step();
    endtask

    task automatic test_wrap_halt();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        pc_in = 32'hFFFFFFFC;
        exec_done = 1'b1;
        halt_req = 1'b1;
        step();
        checks++;
        if (state !== 3'd3 || pc_write !== 1'b1 || pc_next !== 32'h00000000) begin
            fails++;
            $display("FAIL wrap_update state=%0d pw=%b pc_next=%h exp 3/1/00000000",
                     state, pc_write, pc_next);
        end
        exec_done = 1'b0;
        step();
        checks++;
        if (state !== 3'd5 || pc_write !== 1'b0 || fetch_req !== 1'b0) begin
            fails++;
            $display("FAIL halt_enter state=%0d pw=%b fr=%b exp 5/0/0",
                     state, pc_write, fetch_req);
        end
        mem_ready = 1'b1;
        exec_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (state !== 3'd5 || pc_write !== 1'b0 || fetch_req !== 1'b0) begin
                fails++;
                $display("FAIL halt_stay[%0d] state=%0d pw=%b fr=%b exp 5/0/0",
                         i, state, pc_write, fetch_req);
            end
        end
    endtask

    task automatic test_reset_priority();
        stall = 1'b1;
        mem_ready = 1'b1;
        exec_done = 1'b1;
        rst = 1'b1;
        step();
        checks++;
        if (state !== 3'd0 || fault !== 1'b0 || pc_next !== 32'h0 || pc_write !== 1'b0) begin
            fails++;
            $display("FAIL rst_prio state=%0d fault=%b pc_next=%h pw=%b exp 0/0/0/0",
                     state, fault, pc_next, pc_write);
        end
        rst = 1'b0;
        step();
        checks++;
        if (state !== 3'd0 || pc_write !== 1'b1) begin
            fails++;
            $display("FAIL boot_nostall state=%0d pw=%b exp 0/1", state, pc_write);
        end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        test_reset();
        test_boot();
        test_sequential();
        test_jump_priority();
        test_misaligned_branch();
        test_timeout();
        test_timeout_stall();
        test_wrap_halt();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h00000000, PC value written on boot.
REQ-002 Parameter EXC_VECTOR, default 32'h00000180, PC value written on a fault.
REQ-003 Parameter MEM_TIMEOUT, default 15, maximum FETCH wait cycles (range 1..255).
REQ-004 Clock_in  in  1  single clock; all state changes on its rising edge.
REQ-005 Signal_reset  in  1  synchronous, active-high reset.
REQ-006 Pc_in  in  32  current PC register output (Data of pc).
REQ-007 Mem_ready  in  1  instruction memory has returned the word for Fetch_req.
REQ-008 Exec_done  in  1  datapath has finished the current instruction.
REQ-009 Jump_req  in  1  current instruction is a jump; qualified by Exec_done.
REQ-010 Jump_target  in  32  jump destination.
REQ-011 Branch_req  in  1  current instruction is a branch; qualified by Exec_done.
REQ-012 Branch_taken  in  1  branch condition result.
REQ-013 Branch_target  in  32  branch destination.
REQ-014 Stall  in  1  freeze sequencing while high.
REQ-015 Halt_req  in  1  stop after the current PC update.
REQ-016 Pc_next  out  32  value presented to pc In port.
REQ-017 Pc_write  out  1  write enable to pc Signal_write port.
REQ-018 Fetch_req  out  1  instruction fetch request.
REQ-019 State  out  3  current state encoding.
REQ-020 Fault  out  1  sticky fault flag.

Function
REQ-021 States SHALL be BOOT=0, FETCH=1, EXEC=2, UPDATE=3, FAULT=4, HALT=5; codes 6-7 SHALL go to BOOT.
REQ-022 BOOT: Pc_next=RESET_VECTOR, Pc_write=1 for exactly one cycle; next state FETCH.
REQ-023 FETCH: Fetch_req=1; on Mem_ready go to EXEC; wait counter clears on entry.
REQ-024 FETCH with no Mem_ready for MEM_TIMEOUT consecutive non-stalled cycles SHALL go to FAULT.
REQ-025 EXEC: Fetch_req=0; on Exec_done latch the chosen target in Pc_next and go to UPDATE.
REQ-026 Target priority: Jump_req -> Jump_target; else Branch_req&Branch_taken -> Branch_target; else Pc_in+4.
REQ-027 Pc_in+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-028 A chosen target with bits [1:0] != 0 SHALL go to FAULT instead of UPDATE.
REQ-029 UPDATE: Pc_write=1 one cycle with latched Pc_next; next state HALT if Halt_req else FETCH.
REQ-030 FAULT: Pc_next=EXC_VECTOR, Pc_write=1 one cycle, Fault set; next state FETCH.
REQ-031 Fault SHALL stay 1 until reset.
REQ-032 HALT: Pc_write=0, Fetch_req=0; leaves only via reset.
REQ-033 Stall=1 SHALL hold state, Pc_next and wait counter, and force Pc_write=0 and Fetch_req=0; BOOT is not stallable.
REQ-034 Latency: Exec_done at cycle t -> Pc_write at t+1 -> Fetch_req at t+2.
REQ-035 Pc_write SHALL only be asserted in BOOT, UPDATE and FAULT.
REQ-036 Outputs SHALL be registered.

Reset
REQ-037 Signal_reset=1 at an edge SHALL force State=BOOT, Pc_next=0, Pc_write=0, Fetch_req=0, Fault=0, wait counter=0, in any state.
REQ-038 Reset SHALL take priority over Stall, Mem_ready and Exec_done on the same edge.

Verification
REQ-039 Reset release -> one-cycle Pc_write with Pc_next=0, then Fetch_req=1.
REQ-040 Pc_in=32'h00000010, Mem_ready, then Exec_done with no jump or branch -> Pc_next=32'h00000014, Pc_write 1 cycle later.
REQ-041 Exec_done with Jump_req=1, Jump_target=32'h00000100, and Branch_req=Branch_taken=1 -> Pc_next=32'h00000100.
REQ-042 Branch_target=32'h00000102 taken -> FAULT, Pc_next=32'h00000180, Fault=1.
REQ-043 Mem_ready held low for 15 cycles -> FAULT; with Stall=1 for 5 of those cycles -> FAULT after 20 cycles.
REQ-044 Pc_in=32'hFFFFFFFC sequential -> Pc_next=0; Halt_req during UPDATE -> HALT with no further Pc_write until reset.
